point_mult_seq: RTL and testbench



---
 rtl/point_mult_seq_if.sv | 47 ++++
 rtl/point_mult_seq.sv | 95 +++++++++
 tb/tb_point_mult_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/point_mult_seq_if.sv
// Bundle between the pointwise-multiply sequencer and its surroundings:
// operand read ports, multiplier operand/product lanes, result write port
// and the start/busy/done handshake.
// Optional macro POINT_MULT_SEQ_STALL_EN adds the stall input.
interface point_mult_seq_if #(
    parameter int N = 19,
    parameter int D = 8,
    parameter int L = 256
);
    localparam int BEATS = L / D;
    localparam int AW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                start;
    logic                busy;
    logic                done;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [D-1:0][N-1:0] a_rdata;
    logic [D-1:0][N-1:0] b_rdata;
    logic [D-1:0][N-1:0] mult_a;
    logic [D-1:0][N-1:0] mult_b;
    logic [D-1:0][N-1:0] mult_p;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [D-1:0][N-1:0] wr_data;
`ifdef POINT_MULT_SEQ_STALL_EN
    logic                stall;
`endif

    // Sequencer side
    modport master (
`ifdef POINT_MULT_SEQ_STALL_EN
        input  stall,
`endif
        input  start, a_rdata, b_rdata, mult_p,
        output busy, done, rd_en, rd_addr, mult_a, mult_b, wr_en, wr_addr, wr_data
    );

    // Memories / multiplier / controller side
    modport slave (
`ifdef POINT_MULT_SEQ_STALL_EN
        output stall,
`endif
        output start, a_rdata, b_rdata, mult_p,
        input  busy, done, rd_en, rd_addr, mult_a, mult_b, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/point_mult_seq.sv
// Pointwise-multiply sequencer: reads D-lane beats of polynomials A and B,
// registers them into the external combinational modular multiplier,
// registers the product and writes it to the result memory.
// Pipeline per beat: read issue -> operand regs -> result reg/write.
// Optional macro POINT_MULT_SEQ_STALL_EN: stall input freezes the whole
// sequencer (operand memories are expected to hold read data while rd_en=0).
module point_mult_seq #(
    parameter int N = 19,
    parameter int D = 8,
    parameter int L = 256
) (
    input logic           clk,
    input logic           rst_n,
    point_mult_seq_if.master bus
);
    localparam int            BEATS = L / D;
    localparam int            AW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [AW-1:0] LAST  = AW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t              state, state_n;
    logic [AW-1:0]       rd_addr_q, wr_addr_q;
    // [0] read data arriving, [1] operands registered, [2] result write
    logic [2:0]          vld_pipe;
    logic [D-1:0][N-1:0] opa_q, opb_q, prod_q;
    logic                active, hold, rd_go;

    assign active = (state == READ) || (state == DRAIN);
`ifdef POINT_MULT_SEQ_STALL_EN
    assign hold   = bus.stall && active;
`else
    assign hold   = 1'b0;
`endif
    assign rd_go  = (state == READ) && !hold;

    assign bus.busy    = active;
    assign bus.done    = (state == DONE);
    assign bus.rd_en   = rd_go;
    assign bus.rd_addr = rd_addr_q;
    assign bus.mult_a  = opa_q;
    assign bus.mult_b  = opb_q;
    assign bus.wr_en   = vld_pipe[2] && !hold;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = prod_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state: leave DRAIN once the last beat's write is on the bus
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = READ;
            READ:    if (!hold && rd_addr_q == LAST) state_n = DRAIN;
            DRAIN:   if (!hold && vld_pipe[2] && wr_addr_q == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Independent read/write beat counters, wrapping to 0 after the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            if (rd_go)
                rd_addr_q <= (rd_addr_q == LAST) ? '0 : rd_addr_q + 1'b1;
            if (!hold && vld_pipe[2])
                wr_addr_q <= (wr_addr_q == LAST) ? '0 : wr_addr_q + 1'b1;
        end
    end

    // Valid shift register and data registers; everything freezes on hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            prod_q   <= '0;
        end else if (!hold) begin
            vld_pipe <= {vld_pipe[1:0], rd_go};
            if (vld_pipe[0]) begin
                opa_q <= bus.a_rdata;
                opb_q <= bus.b_rdata;
            end
            if (vld_pipe[1])
                prod_q <= bus.mult_p;
        end
    end
endmodule

// File: tb/tb_point_mult_seq.sv
// Bench for point_mult_seq: behavioural operand memories and modular
// multiplier, scoreboard of expected writes filled at read issue and
// drained at result write, plus cycle-position checks per operation.
module tb_point_mult_seq;
    localparam int N  = 19;
    localparam int D  = 8;
    localparam int L  = 256;
    localparam int B  = L / D;
    localparam int AW = 5;
    localparam int Q  = 12289;

    typedef logic [D-1:0][N-1:0] beat_t;
    typedef struct {
        logic [AW-1:0] addr;
        beat_t         data;
    } exp_t;

    logic clk = 0;
    logic rst_n = 1;
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, base = 0, pat = 0;
    bit   armed = 0;
    int   stray = 0, nrd, nwr, ndone, first_rd, last_rd, first_wr, last_wr, done_cyc;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    point_mult_seq_if #(.N(N), .D(D), .L(L)) bus ();
    point_mult_seq_if #(.N(N), .D(D), .L(D)) sbus ();

    point_mult_seq #(.N(N), .D(D), .L(L)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.master));
    point_mult_seq #(.N(N), .D(D), .L(D)) sdut (.clk(clk), .rst_n(rst_n), .bus(sbus.master));

    function automatic beat_t beat_a(input int k);
        beat_t r;
        for (int l = 0; l < D; l++) r[l] = N'((8 * k + l + 97 * pat) % Q);
        return r;
    endfunction

    function automatic beat_t beat_b(input int k);
        beat_t r;
        for (int l = 0; l < D; l++) r[l] = (pat == 0) ? N'(1) : N'((l + 3 * pat + k) % Q);
        return r;
    endfunction

    function automatic beat_t mulbeat(input beat_t a, input beat_t b);
        beat_t r;
        for (int l = 0; l < D; l++) r[l] = N'((64'(a[l]) * 64'(b[l])) % Q);
        return r;
    endfunction

    // Operand memories: registered read, output held while rd_en is low
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.a_rdata <= beat_a(int'(bus.rd_addr));
            bus.b_rdata <= beat_b(int'(bus.rd_addr));
        end
        if (sbus.rd_en) begin
            sbus.a_rdata <= beat_a(0);
            sbus.b_rdata <= beat_b(0);
        end
    end

    // Combinational modular multiplier
    always_comb begin
        bus.mult_p  = mulbeat(bus.mult_a, bus.mult_b);
        sbus.mult_p = mulbeat(sbus.mult_a, sbus.mult_b);
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor / scoreboard on the big instance
    always @(negedge clk) begin
        int   rel;
        exp_t e;
        rel = cyc - base + 1;
        if (rst_n && !armed) begin
            if (bus.rd_en || bus.wr_en || bus.done) stray++;
        end else if (rst_n) begin
            if (bus.rd_en) begin
                nrd++;
                if (nrd == 1) first_rd = rel;
                last_rd = rel;
                e.addr = bus.rd_addr;
                e.data = mulbeat(beat_a(int'(bus.rd_addr)), beat_b(int'(bus.rd_addr)));
                exp_q.push_back(e);
                chk("busy_rd", bus.busy, 1);
            end
            if (bus.wr_en) begin
                nwr++;
                if (nwr == 1) first_wr = rel;
                last_wr = rel;
                if (exp_q.size() == 0) chk("wr_extra", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", bus.wr_addr, e.addr);
                    chk("wr_data", bus.wr_data, e.data);
                end
                chk("busy_wr", bus.busy, 1);
            end
            if (bus.done) begin
                ndone++;
                done_cyc = rel;
                chk("busy_at_done", bus.busy, 0);
            end
        end
    end

    // One operation on the big instance; optional ignored starts and stall
    task automatic run_op(input int delay, input bit ign_start, input bit do_stall, input int pat_i);
        pat = pat_i;
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        base = cyc;
        chk("stray", stray, 0);
        stray = 0; nrd = 0; nwr = 0; ndone = 0;
        first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
        armed = 1;
        for (int c = 1; c <= B + delay + 4; c++) begin
            bus.start = ign_start && (c == 10 || c == B + 4);
`ifdef POINT_MULT_SEQ_STALL_EN
            bus.stall = do_stall && c >= 5 && c <= 7;
`endif
            @(posedge clk); #1;
        end
        bus.start = 0;
`ifdef POINT_MULT_SEQ_STALL_EN
        bus.stall = 0;
`endif
        armed = 0;
        chk("n_rd", nrd, B);
        chk("n_wr", nwr, B);
        chk("n_done", ndone, 1);
        chk("first_rd", first_rd, 1);
        chk("last_rd", last_rd, B + delay);
        chk("first_wr", first_wr, 4);
        chk("last_wr", last_wr, B + 3 + delay);
        chk("done_cyc", done_cyc, B + 4 + delay);
        chk("sb_empty", exp_q.size(), 0);
        chk("busy_after", bus.busy, 0);
    endtask

    initial begin
        bus.start = 0;
        sbus.start = 0;
`ifdef POINT_MULT_SEQ_STALL_EN
        bus.stall = 0;
        sbus.stall = 0;
`endif
        // Mid-cycle asynchronous reset
        #3 rst_n = 0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_mult_a", bus.mult_a, 0);
        chk("rst_mult_b", bus.mult_b, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (20) begin @(posedge clk); #1; end
        chk("idle_quiet", stray, 0);

        // Basic run, B lanes = 1
        run_op(0, 0, 0, 0);
        // Starts in cycle 10 and in the done cycle are ignored
        run_op(0, 1, 0, 1);
        // Start in the cycle after done: rd_en must land in rel cycle 1
        run_op(0, 0, 0, 2);

        // Reset mid-operation
        pat = 3;
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        base = cyc;
        chk("stray", stray, 0);
        stray = 0;
        armed = 1;
        repeat (14) begin @(posedge clk); #1; end
        rst_n = 0;
        armed = 0;
        #1;
        chk("mid_rst_wr_en", bus.wr_en, 0);
        chk("mid_rst_rd_en", bus.rd_en, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_wr_addr", bus.wr_addr, 0);
        chk("mid_rst_wr_data", bus.wr_data, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1;
        repeat (40) begin @(posedge clk); #1; end
        chk("mid_rst_quiet", stray, 0);
        run_op(0, 0, 0, 4);

        // Single-beat instance
        pat = 6;
        sbus.start = 1;
        @(posedge clk); #1;
        sbus.start = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("s_rd_en_c%0d", c), sbus.rd_en, c == 1);
            chk($sformatf("s_wr_en_c%0d", c), sbus.wr_en, c == 4);
            chk($sformatf("s_done_c%0d", c), sbus.done, c == 5);
            chk($sformatf("s_busy_c%0d", c), sbus.busy, c >= 1 && c <= 4);
            if (c == 4) begin
                chk("s_wr_addr", sbus.wr_addr, 0);
                chk("s_wr_data", sbus.wr_data, mulbeat(beat_a(0), beat_b(0)));
            end
            @(posedge clk); #1;
        end

`ifdef POINT_MULT_SEQ_STALL_EN
        // Stall cycles 5..7: writes gap, nothing lost, done three cycles late
        run_op(3, 0, 1, 5);
`endif

        repeat (3) begin @(posedge clk); #1; end
        chk("final_quiet", stray, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
